ksa4_seq_adder: RTL
===================

# ksa4_seq_adder

Multi-cycle wide adder controller that sequences a single 4-bit Kogge-Stone slice over the nibbles of a `4*NIBBLES`-bit operand pair.
- Processes the least-significant nibble first and chains the carry between cycles in a register.
- Trades latency for area: one 4-bit prefix adder serves any operand width.
- Sits between an upstream operand producer and a downstream result consumer, with valid/ready handshakes on both sides.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operation; must be ≥ 1. Operand width `W = 4*NIBBLES`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset. **Decided:** one clock; reset is asynchronous and active-low.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: controller can accept an operand pair.
- `in_a` input W: operand A.
- `in_b` input W: operand B.
- `in_cin` input 1: carry-in for nibble 0.
- `out_valid` output 1: result held for the consumer.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output W: `in_a + in_b + in_cin`, modulo 2^W.
- `out_cout` output 1: carry out of bit W-1.
- `out_zero` output 1: `out_sum == 0`.
- `busy` output 1: state is not IDLE.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready` at a rising edge:
    - latch `in_a`/`in_b` into operand registers;
    - set carry register = `in_cin`;
    - set nibble index = 0;
    - clear sum register;
    - go to RUN.
- **RUN**
  - Each cycle the slice adds `a[4i+3:4i]`, `b[4i+3:4i]` and the carry register.
  - At the edge, write the 4-bit result into `sum[4i+3:4i]` and load the slice carry-out into the carry register.
  - If `i == NIBBLES-1`, go to DONE; otherwise increment `i`.
- **DONE**
  - `out_valid` = 1.
  - `out_sum`, `out_cout` and `out_zero` are driven from registers and stay stable while `out_ready` = 0.
  - On `out_valid & out_ready` at an edge, go to IDLE.
- `in_ready` = 0 in RUN and DONE. Upstream `in_valid` may stay high; it is ignored until IDLE.
- `out_zero` is computed from the complete registered sum in DONE, not per nibble.
- Arithmetic is unsigned with wrap-around modulo 2^W; overflow is reported only via `out_cout`.
- Inputs are sampled only at the acceptance edge. Changing them during RUN has no effect.
- **Asynchronous reset** (any state, including mid-RUN):
  - forces IDLE and aborts the operation;
  - zeroes operands, carry, index and sum registers;
  - no partial result is ever emitted.
- **Outputs during reset:**
  - `in_ready` = 1, since reset forces IDLE and `in_ready` = 1 in IDLE, consistent with the IDLE rule above;
  - `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, `out_zero` = 0, `busy` = 0.

## Timing
- E0 is the acceptance edge.
- Nibble k is registered at edge E(k+1).
- State is DONE and `out_valid` = 1 from E(NIBBLES). Latency from acceptance to `out_valid` is NIBBLES cycles.
- If `out_ready` is already high, the result handshakes at the first edge after `out_valid` rises. IDLE follows, and the next acceptance is possible one edge later.
- Sustained throughput with `out_ready` tied high: one operation per NIBBLES+2 cycles.
- There is no combinational path from `in_*` to `out_*`.
- There is no combinational path from `out_ready` to `in_ready`: `in_ready` depends on state only.
- Critical path: nibble mux, then 4-bit prefix slice, then carry/sum register. This is independent of NIBBLES apart from mux depth.

## Structure
- **Package `ksa4_seq_pkg`:**
  - `NIBBLE_W = 4`;
  - state enum `{IDLE, RUN, DONE}`;
  - index-width function `clog2(NIBBLES)` (minimum 1).
- **Sub-module `ksa4_core`:**
  - purely combinational 4-bit Kogge-Stone adder;
  - ports `a[3:0]`, `b[3:0]`, `cin`, `sum[3:0]`, `cout`;
  - generate/propagate, three prefix levels, sum XOR;
  - instantiated once.
- Controller (FSM, index counter, operand/sum/carry registers, output registers) lives in `ksa4_seq_adder`.

## Test plan
- NIBBLES=4, `0xFFFF + 0x0001`, cin 0 → `out_sum` 0x0000, `out_cout` 1, `out_zero` 1; `out_valid` rises exactly 4 cycles after the acceptance edge.
- NIBBLES=4, `0x1234 + 0x4321`, cin 1 → `out_sum` 0x5556, `out_cout` 0, `out_zero` 0; carry propagates across all nibbles with `0x0FFF + 0x0001` → 0x1000.
- Backpressure: hold `out_ready` = 0 for 6 cycles in DONE → `out_sum`/`out_cout`/`out_valid` stable, `in_ready` = 0 with `in_valid` = 1 held, no second acceptance; release → handshake, IDLE next cycle.
- Reset mid-op: assert `rst_n` = 0 asynchronously two cycles into RUN → all outputs at reset values immediately (`in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, `out_zero` = 0, `busy` = 0); after release, `0x00FF + 0x0001` → 0x0100 with normal latency.
- NIBBLES=1, `0xF + 0xF`, cin 1 → `out_sum` 0xF, `out_cout` 1, latency 1 cycle.
- Streaming with `out_ready` tied 1, `in_valid` tied 1, 8 random operand pairs → each result matches the reference sum, one acceptance every 6 cycles (NIBBLES=4).

Source files
------------

// File: rtl/ksa4_seq_pkg.sv
// Shared constants for the nibble-serial Kogge-Stone adder: slice width, FSM encoding
// and the nibble-index width helper.
package ksa4_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Index counter width; a single-nibble build still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ksa4_core.sv
// Combinational 4-bit Kogge-Stone adder: generate/propagate, three prefix levels, sum XOR.
module ksa4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Position 0 of the 5-entry prefix vector is the carry-in; bit j of the operands is position j+1.
  logic [4:0] g0, p0, g1, p1, g2, p2, g3;

  assign g0 = {a & b, cin};
  assign p0 = {a ^ b, 1'b0};

  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 5; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 5; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
    g3 = g2;
    for (int i = 4; i < 5; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end
  end

  // g3[i] is the carry into operand bit i.
  assign sum  = p0[4:1] ^ g3[3:0];
  assign cout = g3[4];

endmodule

// File: rtl/ksa4_seq_adder.sv
// Wide adder that walks one 4-bit Kogge-Stone slice across the operands, LSB nibble first,
// with valid/ready handshakes on both sides.
module ksa4_seq_adder
  import ksa4_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                        in_cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                        out_cout,
  output logic                        out_zero,
  output logic                        busy
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, slice_sum;
  logic                slice_cout;

  assign a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  ksa4_core u_core (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  // Results are masked outside DONE so a partial sum never appears on the outputs.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_valid ? sum_q : '0;
  assign out_cout  = out_valid & carry_q;
  assign out_zero  = out_valid & (sum_q == '0);

endmodule
